// File: rtl/pmem_rr_arbiter_pkg.sv
// Shared types and constants for the physical-memory port arbiter.
// Used by pmem_rr_arbiter, arb_rr_pick and the bench.
package pmem_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_A = 2'd1,
        ARB_GRANT_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } arb_side_t;

    typedef logic [127:0] lc3b_line;

    localparam int unsigned ARB_STARVE_LIMIT = 4;
    localparam int unsigned ARB_STARVE_W     = 3;

endpackage

// File: rtl/pmem_rr_arbiter_if.sv
// Cache-to-memory line port. A cache or the arbiter is the master.
// Memory, or the arbiter's cache-facing side, is the slave.
interface pmem_rr_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/pmem_rr_arbiter_pick.sv
// Combinational grant selection for the two-way memory arbiter.
// PMEM_ARB_DPRIO_EN: ties favour side B, limited by a starvation count.
module arb_rr_pick
    import pmem_rr_arbiter_pkg::*;
(
    input  logic                    req_a_i,
    input  logic                    req_b_i,
    input  arb_side_t               last_grant_i,
`ifdef PMEM_ARB_DPRIO_EN
    input  logic [ARB_STARVE_W-1:0] starve_cnt_i,
`endif
    output logic                    gnt_a_o,
    output logic                    gnt_b_o
);

    logic tie_to_a;

`ifdef PMEM_ARB_DPRIO_EN
    assign tie_to_a = (starve_cnt_i >= ARB_STARVE_W'(ARB_STARVE_LIMIT));
`else
    assign tie_to_a = (last_grant_i == SIDE_B);
`endif

    assign gnt_a_o = req_a_i & (~req_b_i | tie_to_a);
    assign gnt_b_o = req_b_i & (~req_a_i | ~tie_to_a);

endmodule

// File: rtl/pmem_rr_arbiter.sv
// Registered arbiter sharing one memory port between I-cache (A) and D-cache (B).
// Round-robin by default; define PMEM_ARB_DPRIO_EN for D-cache priority.
module pmem_rr_arbiter
    import pmem_rr_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    pmem_rr_arbiter_if.slave  side_a,
    pmem_rr_arbiter_if.slave  side_b,
    pmem_rr_arbiter_if.master mem,
    output logic              arb_busy_o
);

    arb_state_t        state_q;
    arb_side_t         last_grant_q;
    logic              cmd_rd_q;
    logic              cmd_wr_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [LINE_W-1:0] cmd_wdata_q;
    logic              req_a;
    logic              req_b;
    logic              gnt_a;
    logic              gnt_b;
`ifdef PMEM_ARB_DPRIO_EN
    logic [ARB_STARVE_W-1:0] starve_cnt_q;
`endif

    assign req_a = side_a.pmem_read | side_a.pmem_write;
    assign req_b = side_b.pmem_read | side_b.pmem_write;

    arb_rr_pick u_pick (
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .last_grant_i (last_grant_q),
`ifdef PMEM_ARB_DPRIO_EN
        .starve_cnt_i (starve_cnt_q),
`endif
        .gnt_a_o      (gnt_a),
        .gnt_b_o      (gnt_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the line-wide cmd registers are reset too, so the memory
            // bus is all-zero rather than X straight out of reset.
            state_q      <= ARB_IDLE;
            last_grant_q <= SIDE_B;
            cmd_rd_q     <= 1'b0;
            cmd_wr_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
`ifdef PMEM_ARB_DPRIO_EN
            starve_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    // Write wins over a simultaneous (illegal) read.
                    if (gnt_a) begin
                        state_q     <= ARB_GRANT_A;
                        cmd_wr_q    <= side_a.pmem_write;
                        cmd_rd_q    <= side_a.pmem_read & ~side_a.pmem_write;
                        cmd_addr_q  <= side_a.pmem_address;
                        cmd_wdata_q <= side_a.pmem_wdata;
`ifdef PMEM_ARB_DPRIO_EN
                        starve_cnt_q <= '0;
`endif
                    end else if (gnt_b) begin
                        state_q     <= ARB_GRANT_B;
                        cmd_wr_q    <= side_b.pmem_write;
                        cmd_rd_q    <= side_b.pmem_read & ~side_b.pmem_write;
                        cmd_addr_q  <= side_b.pmem_address;
                        cmd_wdata_q <= side_b.pmem_wdata;
`ifdef PMEM_ARB_DPRIO_EN
                        if (!req_a)
                            starve_cnt_q <= '0;
                        else if (starve_cnt_q != '1)
                            starve_cnt_q <= starve_cnt_q + 1'b1;
`endif
                    end
                end
                ARB_GRANT_A, ARB_GRANT_B: begin
                    if (mem.pmem_resp) begin
                        state_q      <= ARB_IDLE;
                        cmd_rd_q     <= 1'b0;
                        cmd_wr_q     <= 1'b0;
                        last_grant_q <= (state_q == ARB_GRANT_A) ? SIDE_A : SIDE_B;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign mem.pmem_read    = cmd_rd_q;
    assign mem.pmem_write   = cmd_wr_q;
    assign mem.pmem_address = cmd_addr_q;
    assign mem.pmem_wdata   = cmd_wdata_q;

    assign side_a.pmem_rdata = mem.pmem_rdata;
    assign side_b.pmem_rdata = mem.pmem_rdata;
    assign side_a.pmem_resp  = mem.pmem_resp & (state_q == ARB_GRANT_A);
    assign side_b.pmem_resp  = mem.pmem_resp & (state_q == ARB_GRANT_B);

    assign arb_busy_o = (state_q != ARB_IDLE);

    a_no_rdwr_a: assert property (@(posedge clk) disable iff (rst)
        !(side_a.pmem_read && side_a.pmem_write));
    a_no_rdwr_b: assert property (@(posedge clk) disable iff (rst)
        !(side_b.pmem_read && side_b.pmem_write));

endmodule

// File: tb/tb_pmem_rr_arbiter.sv
// Self-checking bench for pmem_rr_arbiter: vector table, scoreboard queue of
// expected memory transactions, and hand-written multi-cycle sequences.
module tb_pmem_rr_arbiter;
    import pmem_rr_arbiter_pkg::*;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic clk = 1'b0;
    logic rst;
    logic arb_busy;

    always #5 clk = ~clk;

    pmem_rr_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) if_a ();
    pmem_rr_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) if_b ();
    pmem_rr_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) if_m ();

    pmem_rr_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .side_a     (if_a),
        .side_b     (if_b),
        .mem        (if_m),
        .arb_busy_o (arb_busy)
    );

    typedef struct {
        bit            side;
        bit            rd;
        bit            wr;
        logic [15:0]   addr;
        lc3b_line      wdata;
        lc3b_line      rdata;
        int            wait_cyc;
        bit            exp_rd;
        bit            exp_wr;
    } txn_t;

    txn_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cnt_a = 0;
    int   cnt_b = 0;

    always @(posedge clk) begin
        if (if_a.pmem_resp) cnt_a++;
        if (if_b.pmem_resp) cnt_b++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic drive_req(input txn_t t, input bit push);
        if (t.side == 1'b0) begin
            if_a.pmem_read    = t.rd;
            if_a.pmem_write   = t.wr;
            if_a.pmem_address = t.addr;
            if_a.pmem_wdata   = t.wdata;
        end else begin
            if_b.pmem_read    = t.rd;
            if_b.pmem_write   = t.wr;
            if_b.pmem_address = t.addr;
            if_b.pmem_wdata   = t.wdata;
        end
        if (push) sb_q.push_back(t);
    endtask

    task automatic clear_req(input bit side);
        if (side == 1'b0) begin
            if_a.pmem_read  = 1'b0;
            if_a.pmem_write = 1'b0;
        end else begin
            if_b.pmem_read  = 1'b0;
            if_b.pmem_write = 1'b0;
        end
    endtask

    task automatic wait_strobe(output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (if_m.pmem_read || if_m.pmem_write) begin
                ok = 1'b1;
                break;
            end
        end
        chk1("strobe_timeout", ok, 1'b1);
    endtask

    // Memory-side responder: pops the next expected transaction, checks the
    // bus, answers after wait_cyc cycles and checks the routed response.
    task automatic service(input bit drop_mid, input bit keep_req, input int exp_lat);
        txn_t e;
        txn_t t;
        int   cyc;
        bit   ok;
        wait_strobe(cyc, ok);
        if (sb_q.size() == 0) begin
            check("sb_underflow", 128'(sb_q.size()), 128'(1));
            return;
        end
        e = sb_q.pop_front();
        if (!ok) return;
        if (exp_lat > 0) check("grant_latency", 128'(cyc), 128'(exp_lat));
        chk1("mem_read", if_m.pmem_read, e.exp_rd);
        chk1("mem_write", if_m.pmem_write, e.exp_wr);
        check("mem_addr", 128'(if_m.pmem_address), 128'(e.addr));
        if (e.exp_wr) check("mem_wdata", if_m.pmem_wdata, e.wdata);
        chk1("busy_during", arb_busy, 1'b1);
        if (drop_mid) begin
            t       = e;
            t.rd    = 1'b0;
            t.wr    = 1'b0;
            t.addr  = 16'h7777;
            drive_req(t, 1'b0);
        end
        for (int i = 0; i < e.wait_cyc; i++) begin
            @(negedge clk);
            check("hold_addr", 128'(if_m.pmem_address), 128'(e.addr));
            chk1("early_resp_a", if_a.pmem_resp, 1'b0);
            chk1("early_resp_b", if_b.pmem_resp, 1'b0);
        end
        if_m.pmem_resp  = 1'b1;
        if_m.pmem_rdata = e.rdata;
        #1;
        chk1("resp_a", if_a.pmem_resp, e.side == 1'b0);
        chk1("resp_b", if_b.pmem_resp, e.side == 1'b1);
        check("rdata_pass", e.side ? if_b.pmem_rdata : if_a.pmem_rdata, e.rdata);
        if (keep_req) begin
            t      = e;
            t.addr = e.addr + 16'd1;
            drive_req(t, 1'b0);
        end else if (!drop_mid) begin
            clear_req(e.side);
        end
        @(negedge clk);
        if_m.pmem_resp = 1'b0;
        chk1("busy_after", arb_busy, 1'b0);
        chk1("read_after", if_m.pmem_read, 1'b0);
        chk1("write_after", if_m.pmem_write, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_req(1'b0);
        clear_req(1'b1);
        if_m.pmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        txn_t vec[5];
        txn_t t;
        int   ca0, cb0, na, nb, scnt;
        bit   s;

        vec[0] = '{side:1'b0, rd:1'b1, wr:1'b0, addr:16'h1230, wdata:'0,
                   rdata:128'hDEAD0000111122223333444455BEEF00 | 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF,
                   wait_cyc:4, exp_rd:1'b1, exp_wr:1'b0};
        vec[1] = '{side:1'b1, rd:1'b1, wr:1'b0, addr:16'h0FF0, wdata:'0,
                   rdata:128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                   wait_cyc:0, exp_rd:1'b1, exp_wr:1'b0};
        vec[2] = '{side:1'b0, rd:1'b0, wr:1'b1, addr:16'hFFFF, wdata:'1,
                   rdata:128'h0, wait_cyc:2, exp_rd:1'b0, exp_wr:1'b1};
        vec[3] = '{side:1'b1, rd:1'b0, wr:1'b1, addr:16'h0000,
                   wdata:128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
                   rdata:128'h5, wait_cyc:3, exp_rd:1'b0, exp_wr:1'b1};
        vec[4] = '{side:1'b0, rd:1'b1, wr:1'b0, addr:16'h8001, wdata:'0,
                   rdata:'1, wait_cyc:1, exp_rd:1'b1, exp_wr:1'b0};

        if_a.pmem_address = '0;
        if_a.pmem_wdata   = '0;
        if_b.pmem_address = '0;
        if_b.pmem_wdata   = '0;
        if_m.pmem_rdata   = '0;
        do_reset();

        // Reset state.
        chk1("rst_busy", arb_busy, 1'b0);
        chk1("rst_read", if_m.pmem_read, 1'b0);
        chk1("rst_write", if_m.pmem_write, 1'b0);
        check("rst_addr", 128'(if_m.pmem_address), 128'(0));
        check("rst_wdata", if_m.pmem_wdata, 128'(0));
        chk1("rst_resp_a", if_a.pmem_resp, 1'b0);
        chk1("rst_resp_b", if_b.pmem_resp, 1'b0);
        if_m.pmem_rdata = 128'h5A5A_0000_FFFF_1111_2222_3333_4444_A5A5;
        #1;
        check("rdata_thru_a", if_a.pmem_rdata, 128'h5A5A_0000_FFFF_1111_2222_3333_4444_A5A5);
        check("rdata_thru_b", if_b.pmem_rdata, 128'h5A5A_0000_FFFF_1111_2222_3333_4444_A5A5);

        // Single-side transactions from idle.
        for (int i = 0; i < 5; i++) begin
            ca0 = cnt_a;
            cb0 = cnt_b;
            drive_req(vec[i], 1'b1);
            service(1'b0, 1'b0, 1);
            check("resp_a_pulses", 128'(cnt_a - ca0), 128'(vec[i].side ? 0 : 1));
            check("resp_b_pulses", 128'(cnt_b - cb0), 128'(vec[i].side ? 1 : 0));
        end

        // Spurious memory response while idle.
        if_m.pmem_resp = 1'b1;
        #1;
        chk1("spur_resp_a", if_a.pmem_resp, 1'b0);
        chk1("spur_resp_b", if_b.pmem_resp, 1'b0);
        @(negedge clk);
        if_m.pmem_resp = 1'b0;
        chk1("spur_busy", arb_busy, 1'b0);

        // Simultaneous A read and B write after reset: A first, then B.
        do_reset();
        cb0 = cnt_b;
        t = '{side:1'b0, rd:1'b1, wr:1'b0, addr:16'h0100, wdata:'0,
              rdata:128'hAAAA, wait_cyc:2, exp_rd:1'b1, exp_wr:1'b0};
        drive_req(t, 1'b1);
        t = '{side:1'b1, rd:1'b0, wr:1'b1, addr:16'h0200, wdata:{16{8'hA5}},
              rdata:128'hBBBB, wait_cyc:2, exp_rd:1'b0, exp_wr:1'b1};
        drive_req(t, 1'b1);
        service(1'b0, 1'b0, 1);
        service(1'b0, 1'b0, 1);
        repeat (2) @(negedge clk);
        check("sim_resp_b_once", 128'(cnt_b - cb0), 128'(1));

        // A drops its request and changes address mid-transaction.
        ca0 = cnt_a;
        t = '{side:1'b0, rd:1'b1, wr:1'b0, addr:16'h3000, wdata:'0,
              rdata:128'hC0FFEE, wait_cyc:3, exp_rd:1'b1, exp_wr:1'b0};
        drive_req(t, 1'b1);
        service(1'b1, 1'b0, 1);
        check("drop_resp_a", 128'(cnt_a - ca0), 128'(1));
        @(negedge clk);
        chk1("drop_no_regrant", arb_busy, 1'b0);

        // Continuous requests from both sides.
        do_reset();
        na   = 0;
        nb   = 0;
        scnt = 0;
        for (int i = 0; i < 10; i++) begin
`ifdef PMEM_ARB_DPRIO_EN
            if (scnt >= 4) begin
                s    = 1'b0;
                scnt = 0;
            end else begin
                s    = 1'b1;
                scnt++;
            end
`else
            s = i[0];
`endif
            t = '{side:s, rd:1'b1, wr:1'b0,
                  addr:(s ? 16'h0B00 + 16'(nb) : 16'h0A00 + 16'(na)),
                  wdata:'0, rdata:{4{32'(i + 1)}}, wait_cyc:1,
                  exp_rd:1'b1, exp_wr:1'b0};
            if (s) nb++; else na++;
            sb_q.push_back(t);
        end
        t = '{side:1'b0, rd:1'b1, wr:1'b0, addr:16'h0A00, wdata:'0,
              rdata:'0, wait_cyc:1, exp_rd:1'b1, exp_wr:1'b0};
        drive_req(t, 1'b0);
        t.side = 1'b1;
        t.addr = 16'h0B00;
        drive_req(t, 1'b0);
        for (int i = 0; i < 10; i++) service(1'b0, 1'b1, 1);
        clear_req(1'b0);
        clear_req(1'b1);
        @(negedge clk);
        chk1("fair_idle", arb_busy, 1'b0);

        // Asynchronous reset in the middle of a B write.
        t = '{side:1'b1, rd:1'b0, wr:1'b1, addr:16'h0400, wdata:{8{16'hBEEF}},
              rdata:'0, wait_cyc:1, exp_rd:1'b0, exp_wr:1'b1};
        drive_req(t, 1'b0);
        begin
            int  cyc;
            bit  ok;
            wait_strobe(cyc, ok);
        end
        chk1("pre_rst_write", if_m.pmem_write, 1'b1);
        chk1("pre_rst_busy", arb_busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("async_rst_write", if_m.pmem_write, 1'b0);
        chk1("async_rst_busy", arb_busy, 1'b0);
        chk1("async_rst_resp_b", if_b.pmem_resp, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back('{side:1'b0, rd:1'b1, wr:1'b0, addr:16'h0500, wdata:'0,
                         rdata:128'h1, wait_cyc:1, exp_rd:1'b1, exp_wr:1'b0});
        drive_req(sb_q[sb_q.size() - 1], 1'b0);
        sb_q.push_back(t);
        service(1'b0, 1'b0, 1);
        service(1'b0, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
